// File: rtl/apb_gpio_pkg.sv
// Shared constants for the APB GPIO port: register map, synchroniser depth
// bounds and the width of the post-reset warm-up counter.
package apb_gpio_pkg;

  localparam logic [4:0] ADDR_IN      = 5'h00;
  localparam logic [4:0] ADDR_OUT     = 5'h01;
  localparam logic [4:0] ADDR_DIR     = 5'h02;
  localparam logic [4:0] ADDR_OUT_SET = 5'h03;
  localparam logic [4:0] ADDR_OUT_CLR = 5'h04;
  localparam logic [4:0] ADDR_RISE_EN = 5'h05;
  localparam logic [4:0] ADDR_FALL_EN = 5'h06;
  localparam logic [4:0] ADDR_STATUS  = 5'h07;
  localparam logic [4:0] ADDR_IRQ_EN  = 5'h08;
  localparam logic [4:0] ADDR_LAST    = ADDR_IRQ_EN;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;

  // Must hold SYNC_MAX+1, the longest warm-up.
  localparam int WARM_W = $clog2(SYNC_MAX + 2);

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pin input synchroniser with a one-cycle-delayed copy for edge detection;
// edge pulses are held off until the chain has flushed after reset.
module gpio_sync_edge
  import apb_gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [WARM_W-1:0]                 warm_q;
  logic                              armed;

  // NOTE: non-blocking assignments make every stage sample its neighbour's
  // pre-edge value, which is what turns this into a shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], pad_in};
      prev_q  <= chain_q[SYNC_STAGES-1];
      if (!armed) warm_q <= warm_q + 1'b1;
    end
  end

  // A pin already high at reset would look like a rising edge until the
  // chain and the delayed copy have both filled.
  assign armed = (warm_q == WARM_DONE);
  assign sync  = chain_q[SYNC_STAGES-1];
  assign rise  = sync & ~prev_q & {WIDTH{armed}};
  assign fall  = ~sync & prev_q & {WIDTH{armed}};

endmodule

// File: rtl/apb_gpio_port.sv
// APB3 GPIO port: output/direction registers with atomic set/clear, and
// edge-capture status feeding a maskable level interrupt.
module apb_gpio_port
  import apb_gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [4:0]       PADDR,
  input  logic [7:0]       PWDATA,
  output logic [7:0]       PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic             irq
);

  logic [WIDTH-1:0] in_sync, rise, fall;
  logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q, irq_en_q;
  logic             irq_q;
  logic             access, unmapped, wr_en, rd_en;
  logic [WIDTH-1:0] wdata, status_set, status_clr, rd_word;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (PCLK),
    .rst    (PRESET),
    .pad_in (pad_in),
    .sync   (in_sync),
    .rise   (rise),
    .fall   (fall)
  );

  assign access   = PSEL & PENABLE;
  assign unmapped = (PADDR > ADDR_LAST);
  assign wr_en    = access & PWRITE & ~unmapped;
  assign rd_en    = access & ~PWRITE;
  assign wdata    = PWDATA[WIDTH-1:0];

  assign status_set = (rise & rise_en_q) | (fall & fall_en_q);
  assign status_clr = (wr_en && PADDR == ADDR_STATUS) ? wdata : '0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_en_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_en) begin
        case (PADDR)
          ADDR_OUT:     out_q     <= wdata;
          ADDR_DIR:     dir_q     <= wdata;
          ADDR_OUT_SET: out_q     <= out_q | wdata;
          ADDR_OUT_CLR: out_q     <= out_q & ~wdata;
          ADDR_RISE_EN: rise_en_q <= wdata;
          ADDR_FALL_EN: fall_en_q <= wdata;
          ADDR_IRQ_EN:  irq_en_q  <= wdata;
          default: ;
        endcase
      end
      // A new edge beats a simultaneous W1C so no event is lost.
      status_q <= (status_q & ~status_clr) | status_set;
      irq_q    <= |(status_q & irq_en_q);
    end
  end

  // NOTE: defaulting every output before the case keeps this purely
  // combinational; a missed branch would otherwise infer a latch.
  always_comb begin
    rd_word = '0;
    PRDATA  = '0;
    case (PADDR)
      ADDR_IN:      rd_word = in_sync;
      ADDR_OUT:     rd_word = out_q;
      ADDR_DIR:     rd_word = dir_q;
      ADDR_RISE_EN: rd_word = rise_en_q;
      ADDR_FALL_EN: rd_word = fall_en_q;
      ADDR_STATUS:  rd_word = status_q;
      ADDR_IRQ_EN:  rd_word = irq_en_q;
      default:      rd_word = '0;
    endcase
    if (rd_en) PRDATA[WIDTH-1:0] = rd_word;
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = access & unmapped;
  assign pad_out = out_q;
  assign pad_oe  = dir_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_apb_gpio_port.sv
// Directed bench for apb_gpio_port: a default instance (8 pins, 2 sync stages)
// and a narrow one (4 pins, 3 sync stages) share the APB bus.
module tb_apb_gpio_port;
  import apb_gpio_pkg::*;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       PSEL, PENABLE, PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;

  logic [7:0] prdata0, prdata1;
  logic       pready0, pready1, pslverr0, pslverr1;
  logic [7:0] pad_in0, pad_out0, pad_oe0;
  logic [3:0] pad_in1, pad_out1, pad_oe1;
  logic       irq0, irq1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] rd0, rd1;
  logic       err0, rdy0;

  always #5 PCLK = ~PCLK;

  apb_gpio_port u_dut0 (
    .PCLK (PCLK), .PRESET (PRESET), .PSEL (PSEL), .PENABLE (PENABLE),
    .PWRITE (PWRITE), .PADDR (PADDR), .PWDATA (PWDATA), .PRDATA (prdata0),
    .PREADY (pready0), .PSLVERR (pslverr0), .pad_in (pad_in0),
    .pad_out (pad_out0), .pad_oe (pad_oe0), .irq (irq0)
  );

  apb_gpio_port #(.WIDTH(4), .SYNC_STAGES(3)) u_dut1 (
    .PCLK (PCLK), .PRESET (PRESET), .PSEL (PSEL), .PENABLE (PENABLE),
    .PWRITE (PWRITE), .PADDR (PADDR), .PWDATA (PWDATA), .PRDATA (prdata1),
    .PREADY (pready1), .PSLVERR (pslverr1), .pad_in (pad_in1),
    .pad_out (pad_out1), .pad_oe (pad_oe1), .irq (irq1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic bus_idle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
  endtask

  // Commit happens on the second edge; returns just after it.
  task automatic apb_write(input logic [4:0] a, input logic [7:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    tick();
    PENABLE = 1'b1;
    #1;
    err = pslverr0;
    tick();
    bus_idle();
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [7:0] d0,
                          output logic [7:0] d1, output logic err, output logic rdy);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    tick();
    PENABLE = 1'b1;
    #1;
    d0  = prdata0;
    d1  = prdata1;
    err = pslverr0;
    rdy = pready0;
    tick();
    bus_idle();
  endtask

  initial begin
    bus_idle();
    PRESET  = 1'b1;
    pad_in0 = 8'hFF;
    pad_in1 = 4'hF;
    tick(3);

    // Reset state
    check("rst_pad_out", pad_out0, 8'h00);
    check("rst_pad_oe", pad_oe0, 8'h00);
    check("rst_irq", {7'd0, irq0}, 8'h00);
    check("rst_pslverr", {7'd0, pslverr0}, 8'h00);
    check("rst_prdata", prdata0, 8'h00);
    check("rst_pready", {7'd0, pready0}, 8'h01);

    // Release reset with pins high; arm rising capture at once so only the
    // warm-up mask can keep STATUS clear.
    PRESET = 1'b0;
    apb_write(ADDR_RISE_EN, 8'hFF, err0);
    apb_read(ADDR_IN, rd0, rd1, err0, rdy0);
    check("warm_in0", rd0, 8'hFF);
    check("warm_in1", rd1, 8'h0F);
    apb_read(ADDR_STATUS, rd0, rd1, err0, rdy0);
    check("warm_status0", rd0, 8'h00);
    check("warm_status1", rd1, 8'h00);
    check("warm_irq", {7'd0, irq0}, 8'h00);
    apb_write(ADDR_RISE_EN, 8'h00, err0);
    pad_in0 = 8'h00;
    tick(4);

    // Output and direction registers with atomic set/clear
    apb_write(ADDR_DIR, 8'h0F, err0);
    check("dir_pad_oe", pad_oe0, 8'h0F);
    apb_write(ADDR_OUT, 8'hA5, err0);
    check("out_pad_out", pad_out0, 8'hA5);
    apb_write(ADDR_OUT_SET, 8'h40, err0);
    check("set_pad_out", pad_out0, 8'hE5);
    apb_write(ADDR_OUT_CLR, 8'h01, err0);
    check("clr_pad_out", pad_out0, 8'hE4);
    apb_read(ADDR_OUT, rd0, rd1, err0, rdy0);
    check("out_read", rd0, 8'hE4);
    apb_read(ADDR_DIR, rd0, rd1, err0, rdy0);
    check("dir_read", rd0, 8'h0F);
    apb_read(ADDR_OUT_SET, rd0, rd1, err0, rdy0);
    check("wo_reads_zero", rd0, 8'h00);

    // Rising edge on pin 0: STATUS on edge 3, irq on edge 4
    apb_write(ADDR_RISE_EN, 8'h01, err0);
    apb_write(ADDR_IRQ_EN, 8'h01, err0);
    pad_in0 = 8'h01;
    tick(3);
    check("rise_irq_not_yet", {7'd0, irq0}, 8'h00);
    tick();
    check("rise_irq_set", {7'd0, irq0}, 8'h01);
    apb_read(ADDR_STATUS, rd0, rd1, err0, rdy0);
    check("rise_status", rd0, 8'h01);
    apb_write(ADDR_STATUS, 8'h01, err0);
    check("w1c_irq_still_high", {7'd0, irq0}, 8'h01);
    tick();
    check("w1c_irq_low", {7'd0, irq0}, 8'h00);
    apb_read(ADDR_STATUS, rd0, rd1, err0, rdy0);
    check("w1c_status", rd0, 8'h00);

    // Falling edge on pin 3 colliding with a W1C of bit 3
    apb_write(ADDR_FALL_EN, 8'h08, err0);
    pad_in0 = 8'h09;
    tick(4);
    pad_in0 = 8'h01;
    tick(4);
    apb_read(ADDR_STATUS, rd0, rd1, err0, rdy0);
    check("fall_status", rd0, 8'h08);
    check("fall_irq_masked", {7'd0, irq0}, 8'h00);
    pad_in0 = 8'h09;
    tick(4);
    pad_in0 = 8'h01;
    tick();
    apb_write(ADDR_STATUS, 8'h08, err0);
    tick();
    apb_read(ADDR_STATUS, rd0, rd1, err0, rdy0);
    check("set_beats_w1c", rd0, 8'h08);
    apb_write(ADDR_STATUS, 8'h08, err0);
    apb_read(ADDR_STATUS, rd0, rd1, err0, rdy0);
    check("w1c_bit3", rd0, 8'h00);

    // Unmapped addresses and the read-only IN register
    apb_read(5'h10, rd0, rd1, err0, rdy0);
    check("unmapped_prdata", rd0, 8'h00);
    check("unmapped_pslverr", {7'd0, err0}, 8'h01);
    check("unmapped_pready", {7'd0, rdy0}, 8'h01);
    apb_write(5'h10, 8'hFF, err0);
    check("unmapped_wr_pslverr", {7'd0, err0}, 8'h01);
    apb_read(5'h09, rd0, rd1, err0, rdy0);
    check("addr09_pslverr", {7'd0, err0}, 8'h01);
    apb_read(ADDR_IRQ_EN, rd0, rd1, err0, rdy0);
    check("addr08_pslverr", {7'd0, err0}, 8'h00);
    check("irq_en_read", rd0, 8'h01);
    apb_write(ADDR_IN, 8'hFF, err0);
    check("in_wr_no_err", {7'd0, err0}, 8'h00);
    apb_read(ADDR_OUT, rd0, rd1, err0, rdy0);
    check("unmapped_out_kept", rd0, 8'hE4);
    apb_read(ADDR_DIR, rd0, rd1, err0, rdy0);
    check("unmapped_dir_kept", rd0, 8'h0F);
    apb_read(ADDR_RISE_EN, rd0, rd1, err0, rdy0);
    check("unmapped_rise_kept", rd0, 8'h01);
    apb_read(ADDR_FALL_EN, rd0, rd1, err0, rdy0);
    check("unmapped_fall_kept", rd0, 8'h08);
    check("unmapped_pad_out", pad_out0, 8'hE4);

    // Narrow instance: upper register bits read 0
    apb_write(ADDR_OUT, 8'hFF, err0);
    apb_read(ADDR_OUT, rd0, rd1, err0, rdy0);
    check("w8_out_read", rd0, 8'hFF);
    check("w4_out_read", rd1, 8'h0F);
    check("w4_pad_out", {4'd0, pad_out1}, 8'h0F);

    // IN latency with a held read access: 2 edges wide, 3 edges narrow
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = ADDR_IN; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    pad_in0 = 8'h00;
    pad_in1 = 4'h5;
    tick();
    check("lat_e1_in0", prdata0, 8'h01);
    check("lat_e1_in1", prdata1, 8'h0F);
    tick();
    check("lat_e2_in0", prdata0, 8'h00);
    check("lat_e2_in1", prdata1, 8'h0F);
    tick();
    check("lat_e3_in1", prdata1, 8'h05);
    bus_idle();

    // Reset during a write access phase aborts it
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = ADDR_OUT; PWDATA = 8'h33; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    #2;
    PRESET = 1'b1;
    tick();
    bus_idle();
    PRESET = 1'b0;
    check("midrst_pad_out", pad_out0, 8'h00);
    check("midrst_pad_oe", pad_oe0, 8'h00);
    apb_read(ADDR_OUT, rd0, rd1, err0, rdy0);
    check("midrst_out_read", rd0, 8'h00);
    apb_read(ADDR_IRQ_EN, rd0, rd1, err0, rdy0);
    check("midrst_irq_en", rd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_gpio_port.md
# apb_gpio_port

Parametrised APB3 GPIO port that succeeds the fixed 8-bit input-synchroniser/output-register pair hanging off the debugger's APB bus. It provides a configurable-width pad interface with a per-pin direction register and atomic set/clear. Rising/falling edge capture on synchronised inputs drives a maskable level interrupt. It sits on the APB bus driven by the I2C bridge, alongside `debugger_apb`.

## Interface
Parameters:
- `WIDTH`, 8, number of pins, 1..8; register bits above WIDTH-1 read 0, writes ignored
- `SYNC_STAGES`, 2, input synchroniser depth, 2..4

Ports:
- `PCLK` in 1: single clock for all logic
- `PRESET` in 1: reset, asynchronous, active-high; all state cleared on assertion
- `PSEL`, `PENABLE`, `PWRITE` in 1: APB3 control
- `PADDR` in 5: byte address
- `PWDATA` in 8: write data
- `PRDATA` out 8: read data
- `PREADY` out 1: tied 1 (zero wait states)
- `PSLVERR` out 1: error on unmapped access
- `pad_in` in WIDTH: asynchronous pin inputs
- `pad_out` out WIDTH: output values
- `pad_oe` out WIDTH: 1 = drive
- `irq` out 1: level interrupt

## Operation
- Register map:
  - 0x00 IN (RO, synchronised input)
  - 0x01 OUT (RW)
  - 0x02 DIR (RW, drives pad_oe)
  - 0x03 OUT_SET (WO, 1 sets OUT bit)
  - 0x04 OUT_CLR (WO, 1 clears OUT bit)
  - 0x05 RISE_EN (RW)
  - 0x06 FALL_EN (RW)
  - 0x07 STATUS (W1C)
  - 0x08 IRQ_EN (RW)
- Read-only and write-only addresses read 0. Writes to IN are ignored without error.
- Addresses 0x09-0x1F:
  - PRDATA=0
  - PSLVERR=1 in the access phase
  - writes have no effect
- Write commits on the PCLK edge with PSEL&PENABLE&PWRITE.
- PRDATA is combinational from PADDR when PSEL&PENABLE&!PWRITE, otherwise 0.
- `pad_out`=OUT and `pad_oe`=DIR, both registered. Output pins still feed IN (readback of driven level).
- Edge detect compares the last sync stage with a one-cycle-delayed copy. STATUS[i] sets on a rising edge when RISE_EN[i], and on a falling edge when FALL_EN[i].
- Same-cycle set and W1C on one bit: set wins.
- `irq` = registered |(STATUS & IRQ_EN).
- Warm-up counter: after reset deassertion, edge capture is masked for SYNC_STAGES+1 cycles, so a pin already high at reset produces no spurious rising edge.
- Reset values: all registers 0, sync chain 0, pad_out=0, pad_oe=0, irq=0, PSLVERR=0, PRDATA=0.
- Reset mid-transfer aborts it; no register keeps partial state.

## Timing
- pad_in change to IN visible: SYNC_STAGES PCLK edges.
- Edge to STATUS set: SYNC_STAGES+1 edges.
- STATUS to irq: +1 edge.
- Write to OUT/DIR/OUT_SET/OUT_CLR to pad_out/pad_oe: 1 edge after the access-phase edge.
- STATUS clear to irq low: 1 edge after the clear edge.
- APB: zero wait states; back-to-back transfers are supported.

## Structure
- Package `apb_gpio_pkg`: register address localparams, `SYNC_STAGES` bounds, warm-up count width.
- One sub-module, `gpio_sync_edge`: per-pin synchroniser, delayed copy, rise/fall pulses and warm-up mask. It is instantiated once with WIDTH lanes.

## Test plan
- Reset with pad_in=0xFF held → after SYNC_STAGES+1 cycles IN reads 0xFF, STATUS=0x00, irq=0.
- Write DIR=0x0F, OUT=0xA5, OUT_SET=0x40, OUT_CLR=0x01 → pad_oe=0x0F, pad_out=0xE4, OUT reads 0xE4.
- RISE_EN=0x01, IRQ_EN=0x01, pad_in[0] 0→1 → STATUS=0x01 at SYNC_STAGES+1, irq=1 one cycle later; write STATUS=0x01 → irq=0 next cycle.
- Falling edge on bit 3 in the same cycle as a W1C of bit 3, with FALL_EN=0x08 → STATUS[3] stays 1.
- Read 0x10 → PRDATA=0, PSLVERR=1, PREADY=1; write 0x10 → all registers unchanged.
- WIDTH=4, SYNC_STAGES=3: write OUT=0xFF → reads 0x0F; IN latency measured at 3 cycles.
